// File: rtl/vga_text_writer.sv
// Character-stream text-buffer writer: pops codes from a FWFT FIFO and writes {bg, fg, char} cells.
// Optional macro VGA_WRAP_CLEAR_EN: every row advance blanks the newly entered row.
module vga_text_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 60
) (
    input  logic        clk_in,
    input  logic        rst_out,
    input  logic        fifo_ready,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd,
    input  logic [7:0]  fg_color,
    input  logic [7:0]  bg_color,
    output logic        VGA_we,
    output logic [12:0] write_addr,
    output logic [23:0] ASCII,
    output logic        busy,
    output logic [5:0]  cursor_row,
    output logic [6:0]  cursor_col
);

    localparam int CELLS = COLS * ROWS;

    typedef enum logic [1:0] {IDLE, DECODE, CLRLINE, CLRALL} state_t;

    state_t      state, state_nxt;
    logic [7:0]  char_q, char_nxt;
    logic [7:0]  fg_q, fg_nxt, bg_q, bg_nxt;
    logic [12:0] fill_cnt, fill_nxt;
    logic [12:0] row_base;
    logic [12:0] addr_nxt;
    logic [23:0] ascii_nxt;
    logic [5:0]  row_nxt;
    logic [6:0]  col_nxt;
    logic        rd_nxt, we_nxt, busy_nxt;
    logic        rst_q;

    function automatic logic [5:0] row_inc(input logic [5:0] r);
        return (r == 6'(ROWS - 1)) ? 6'd0 : r + 6'd1;
    endfunction

    assign row_base = 13'(cursor_row) * 13'(COLS);

    always_comb begin
        state_nxt = state;
        char_nxt  = char_q;
        fg_nxt    = fg_q;
        bg_nxt    = bg_q;
        fill_nxt  = fill_cnt;
        rd_nxt    = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = write_addr;
        ascii_nxt = ASCII;
        row_nxt   = cursor_row;
        col_nxt   = cursor_col;

        case (state)
            IDLE: begin
                // rst_q keeps the FIFO untouched in the first cycle after reset release
                if (fifo_ready && !rst_q) begin
                    char_nxt  = fifo_data;
                    rd_nxt    = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                state_nxt = IDLE;
                fg_nxt    = fg_color;
                bg_nxt    = bg_color;
                fill_nxt  = 13'd0;
                if (char_q >= 8'h20 && char_q <= 8'h7E) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = row_base + 13'(cursor_col);
                    ascii_nxt = {bg_color, fg_color, char_q};
                    if (cursor_col == 7'(COLS - 1)) begin
                        col_nxt = 7'd0;
                        row_nxt = row_inc(cursor_row);
`ifdef VGA_WRAP_CLEAR_EN
                        state_nxt = CLRLINE;
`endif
                    end else begin
                        col_nxt = cursor_col + 7'd1;
                    end
                end else begin
                    case (char_q)
                        8'h0A: begin
                            col_nxt = 7'd0;
                            row_nxt = row_inc(cursor_row);
`ifdef VGA_WRAP_CLEAR_EN
                            state_nxt = CLRLINE;
`endif
                        end
                        8'h0D: col_nxt = 7'd0;
                        8'h08: begin
                            if (cursor_col != 7'd0) begin
                                col_nxt   = cursor_col - 7'd1;
                                we_nxt    = 1'b1;
                                addr_nxt  = row_base + 13'(cursor_col - 7'd1);
                                ascii_nxt = {bg_color, fg_color, 8'h20};
                            end
                        end
                        8'h0C: state_nxt = CLRALL;
                        default: ;
                    endcase
                end
            end
`ifdef VGA_WRAP_CLEAR_EN
            CLRLINE: begin
                // cursor_row already points at the row being blanked
                we_nxt    = 1'b1;
                addr_nxt  = row_base + fill_cnt;
                ascii_nxt = {bg_q, fg_q, 8'h20};
                if (fill_cnt == 13'(COLS - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    fill_nxt = fill_cnt + 13'd1;
                end
            end
`endif
            CLRALL: begin
                we_nxt    = 1'b1;
                addr_nxt  = fill_cnt;
                ascii_nxt = {bg_q, fg_q, 8'h20};
                if (fill_cnt == 13'(CELLS - 1)) begin
                    state_nxt = IDLE;
                    row_nxt   = 6'd0;
                    col_nxt   = 7'd0;
                end else begin
                    fill_nxt = fill_cnt + 13'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // busy also covers the cycle in which the final write is presented
        busy_nxt = (state_nxt != IDLE) || we_nxt;
    end

    always_ff @(posedge clk_in) begin
        rst_q <= rst_out;
        if (rst_out) begin
            state      <= IDLE;
            fifo_rd    <= 1'b0;
            VGA_we     <= 1'b0;
            busy       <= 1'b0;
            cursor_row <= 6'd0;
            cursor_col <= 7'd0;
            write_addr <= 13'd0;
            ASCII      <= 24'h000020;
            fill_cnt   <= 13'd0;
        end else begin
            state      <= state_nxt;
            fifo_rd    <= rd_nxt;
            VGA_we     <= we_nxt;
            busy       <= busy_nxt;
            cursor_row <= row_nxt;
            cursor_col <= col_nxt;
            write_addr <= addr_nxt;
            ASCII      <= ascii_nxt;
            fill_cnt   <= fill_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        char_q <= char_nxt;
        fg_q   <= fg_nxt;
        bg_q   <= bg_nxt;
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed testbench for vga_text_writer with a queue-backed FWFT FIFO model and a write log.
module tb_vga_text_writer;

    logic        clk_in = 1'b0;
    logic        rst_out = 1'b1;
    logic        fifo_ready = 1'b0;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd;
    logic [7:0]  fg_color = 8'hFF;
    logic [7:0]  bg_color = 8'h03;
    logic        VGA_we;
    logic [12:0] write_addr;
    logic [23:0] ASCII;
    logic        busy;
    logic [5:0]  cursor_row;
    logic [6:0]  cursor_col;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  fq[$];
    int          log_addr[$];
    logic [23:0] log_ascii[$];
    int          log_cyc[$];

    vga_text_writer #(.COLS(80), .ROWS(60)) dut (
        .clk_in(clk_in), .rst_out(rst_out), .fifo_ready(fifo_ready), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd), .fg_color(fg_color), .bg_color(bg_color), .VGA_we(VGA_we),
        .write_addr(write_addr), .ASCII(ASCII), .busy(busy),
        .cursor_row(cursor_row), .cursor_col(cursor_col)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // FIFO model and write log, both serviced on the falling edge
    always @(negedge clk_in) begin
        if (fifo_rd && fq.size() > 0) fq.delete(0);
        fifo_ready = (fq.size() != 0);
        fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
        if (VGA_we) begin
            log_addr.push_back(int'(write_addr));
            log_ascii.push_back(ASCII);
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [7:0] c);
        fq.push_back(c);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_ascii.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        rst_out = 1'b1;
        tick();
        tick();
        rst_out = 1'b0;
        tick();
        tick();
        clear_log();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        bit done = 0;
        while (!done && n < 20000) begin
            tick();
            n++;
            if (fq.size() == 0 && !busy && !fifo_rd) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: still busy after %0d cycles", name, n);
        end
    endtask

    task automatic test_reset();
        fg_color = 8'hFF;
        bg_color = 8'h03;
        rst_out = 1'b1;
        push(8'h41);
        repeat (3) tick();
        checks++;
        if ({fifo_rd, VGA_we, busy, cursor_row, cursor_col, write_addr, ASCII} !==
            {1'b0, 1'b0, 1'b0, 6'd0, 7'd0, 13'd0, 24'h000020}) begin
            errors++;
            $display("FAIL reset_values: rd=%b we=%b busy=%b row=%0d col=%0d addr=%0d ascii=%h expected 0 0 0 0 0 0 000020",
                     fifo_rd, VGA_we, busy, cursor_row, cursor_col, write_addr, ASCII);
        end
        rst_out = 1'b0;
        tick();
        checks++;
        if (fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL release_no_pop: fifo_rd=%b expected 0", fifo_rd);
        end
        tick();
        checks++;
        if (fifo_rd !== 1'b1 || VGA_we !== 1'b0) begin
            errors++;
            $display("FAIL first_pop: fifo_rd=%b we=%b expected 1 0", fifo_rd, VGA_we);
        end
        tick();
        checks++;
        if ({fifo_rd, VGA_we, write_addr, ASCII} !== {1'b0, 1'b1, 13'd0, 24'h03FF41}) begin
            errors++;
            $display("FAIL write_A: rd=%b we=%b addr=%0d ascii=%h expected 0 1 0 03ff41",
                     fifo_rd, VGA_we, write_addr, ASCII);
        end
        checks++;
        if ({cursor_row, cursor_col} !== {6'd0, 7'd1}) begin
            errors++;
            $display("FAIL cursor_after_A: (%0d,%0d) expected (0,1)", cursor_row, cursor_col);
        end
        tick();
        checks++;
        if ({VGA_we, write_addr, ASCII} !== {1'b0, 13'd0, 24'h03FF41}) begin
            errors++;
            $display("FAIL hold_after_write: we=%b addr=%0d ascii=%h expected 0 0 03ff41",
                     VGA_we, write_addr, ASCII);
        end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        int last_addr = -1;
        logic [23:0] last_ascii = 24'h0;
        int bad_gap = 0;
        int prev_cyc = -1;
        do_reset();
        for (int i = 0; i < 81; i++) push(8'h41 + 8'(i % 26));
        wait_idle("b2b");
        for (int k = 0; k < log_addr.size(); k++) begin
            if (log_ascii[k][7:0] != 8'h20) begin
                cnt++;
                last_addr = log_addr[k];
                last_ascii = log_ascii[k];
`ifndef VGA_WRAP_CLEAR_EN
                if (prev_cyc >= 0 && log_cyc[k] - prev_cyc != 2) bad_gap++;
                prev_cyc = log_cyc[k];
`endif
            end
        end
        checks++;
        if (cnt != 81) begin
            errors++;
            $display("FAIL b2b_count: %0d character writes expected 81", cnt);
        end
        checks++;
        if (last_addr != 80 || last_ascii !== 24'h03FF43) begin
            errors++;
            $display("FAIL b2b_81st: addr=%0d ascii=%h expected 80 03ff43", last_addr, last_ascii);
        end
        checks++;
        if ({cursor_row, cursor_col} !== {6'd1, 7'd1}) begin
            errors++;
            $display("FAIL b2b_cursor: (%0d,%0d) expected (1,1)", cursor_row, cursor_col);
        end
`ifndef VGA_WRAP_CLEAR_EN
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL b2b_rate: %0d write gaps differ from 2 cycles, expected 0", bad_gap);
        end
`endif
    endtask

    task automatic test_backspace();
        do_reset();
        repeat (5) push(8'h78);
        wait_idle("bs_setup");
        clear_log();
        push(8'h08);
        wait_idle("bs");
        checks++;
        if (log_addr.size() != 1) begin
            errors++;
            $display("FAIL bs_write_count: %0d expected 1", log_addr.size());
        end else begin
            checks++;
            if (log_addr[0] != 4 || log_ascii[0] !== 24'h03FF20) begin
                errors++;
                $display("FAIL bs_write: addr=%0d ascii=%h expected 4 03ff20", log_addr[0], log_ascii[0]);
            end
        end
        checks++;
        if ({cursor_row, cursor_col} !== {6'd0, 7'd4}) begin
            errors++;
            $display("FAIL bs_cursor: (%0d,%0d) expected (0,4)", cursor_row, cursor_col);
        end
        do_reset();
        push(8'h08);
        wait_idle("bs_col0");
        checks++;
        if (log_addr.size() != 0 || {cursor_row, cursor_col} !== 13'd0) begin
            errors++;
            $display("FAIL bs_col0: writes=%0d cursor=(%0d,%0d) expected 0 (0,0)",
                     log_addr.size(), cursor_row, cursor_col);
        end
    endtask

    task automatic test_control_codes();
        do_reset();
        push(8'h71);
        push(8'h71);
        wait_idle("cr_setup");
        clear_log();
        push(8'h0D);
        wait_idle("cr");
        checks++;
        if (log_addr.size() != 0 || {cursor_row, cursor_col} !== 13'd0) begin
            errors++;
            $display("FAIL cr: writes=%0d cursor=(%0d,%0d) expected 0 (0,0)",
                     log_addr.size(), cursor_row, cursor_col);
        end
        push(8'h72);
        push(8'h01);
        push(8'h7F);
        push(8'hFF);
        push(8'h1F);
        wait_idle("drop");
        checks++;
        if (log_addr.size() != 1 || {cursor_row, cursor_col} !== {6'd0, 7'd1}) begin
            errors++;
            $display("FAIL dropped_codes: writes=%0d cursor=(%0d,%0d) expected 1 (0,1)",
                     log_addr.size(), cursor_row, cursor_col);
        end
    endtask

    task automatic test_line_feed_wrap();
        int bad = 0;
        do_reset();
        repeat (59) push(8'h0A);
        repeat (10) push(8'h61);
        wait_idle("lf_setup");
        checks++;
        if ({cursor_row, cursor_col} !== {6'd59, 7'd10}) begin
            errors++;
            $display("FAIL lf_setup_cursor: (%0d,%0d) expected (59,10)", cursor_row, cursor_col);
        end
        checks++;
        if (log_addr.size() == 0 || log_addr[log_addr.size() - 1] != 4729) begin
            errors++;
            $display("FAIL lf_row59_write: last addr=%0d expected 4729",
                     (log_addr.size() == 0) ? -1 : log_addr[log_addr.size() - 1]);
        end
        clear_log();
        push(8'h0A);
        wait_idle("lf_wrap");
        checks++;
        if ({cursor_row, cursor_col} !== 13'd0) begin
            errors++;
            $display("FAIL lf_wrap_cursor: (%0d,%0d) expected (0,0)", cursor_row, cursor_col);
        end
`ifdef VGA_WRAP_CLEAR_EN
        for (int k = 0; k < log_addr.size(); k++)
            if (log_addr[k] != k || log_ascii[k] !== 24'h03FF20) bad++;
        checks++;
        if (log_addr.size() != 80 || bad != 0) begin
            errors++;
            $display("FAIL lf_wrap_clear: writes=%0d bad=%0d expected 80 0", log_addr.size(), bad);
        end
`else
        checks++;
        if (log_addr.size() != 0 || bad != 0) begin
            errors++;
            $display("FAIL lf_wrap_writes: writes=%0d expected 0", log_addr.size());
        end
`endif
    endtask

    task automatic test_clear_all();
        int n = 0;
        int bad_addr = 0;
        int bad_busy = 0;
        int bad_rd = 0;
        bit done = 0;
        logic [23:0] last_ascii = 24'h0;
        fg_color = 8'h1C;
        bg_color = 8'hE0;
        do_reset();
        repeat (3) push(8'h6B);
        wait_idle("ff_setup");
        clear_log();
        push(8'h0C);
        push(8'h5A);
        for (int t = 0; t < 6000 && !done; t++) begin
            tick();
            if (VGA_we) begin
                if (int'(write_addr) != n) bad_addr++;
                if (!busy) bad_busy++;
                if (fifo_rd) bad_rd++;
                last_ascii = ASCII;
                n++;
            end else if (n > 0) begin
                done = 1;
            end
        end
        checks++;
        if (n != 4800 || bad_addr != 0) begin
            errors++;
            $display("FAIL ff_writes: count=%0d bad_addr=%0d expected 4800 0", n, bad_addr);
        end
        checks++;
        if (bad_busy != 0 || bad_rd != 0) begin
            errors++;
            $display("FAIL ff_busy_nord: not_busy=%0d popped=%0d expected 0 0", bad_busy, bad_rd);
        end
        checks++;
        if (last_ascii !== 24'hE01C20 || {cursor_row, cursor_col} !== 13'd0) begin
            errors++;
            $display("FAIL ff_end: ascii=%h cursor=(%0d,%0d) expected e01c20 (0,0)",
                     last_ascii, cursor_row, cursor_col);
        end
        wait_idle("ff_after");
        checks++;
        if (log_ascii.size() == 0 || log_ascii[log_ascii.size() - 1] !== 24'hE01C5A ||
            log_addr[log_addr.size() - 1] != 0 || {cursor_row, cursor_col} !== {6'd0, 7'd1}) begin
            errors++;
            $display("FAIL ff_next_char: writes=%0d cursor=(%0d,%0d) expected Z at 0 and (0,1)",
                     log_ascii.size(), cursor_row, cursor_col);
        end
        fg_color = 8'hFF;
        bg_color = 8'h03;
    endtask

    task automatic test_reset_mid_clear();
        bit found = 0;
        do_reset();
        push(8'h0C);
        for (int t = 0; t < 3000 && !found; t++) begin
            tick();
            if (VGA_we && write_addr == 13'd1000) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midclr_reach: addr 1000 not written, got %0d", write_addr);
        end
        rst_out = 1'b1;
        tick();
        checks++;
        if ({fifo_rd, VGA_we, busy, cursor_row, cursor_col, write_addr, ASCII} !==
            {1'b0, 1'b0, 1'b0, 6'd0, 7'd0, 13'd0, 24'h000020}) begin
            errors++;
            $display("FAIL midclr_reset: rd=%b we=%b busy=%b row=%0d col=%0d addr=%0d ascii=%h expected 0 0 0 0 0 0 000020",
                     fifo_rd, VGA_we, busy, cursor_row, cursor_col, write_addr, ASCII);
        end
        rst_out = 1'b0;
        tick();
        tick();
        checks++;
        if (VGA_we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midclr_aborted: we=%b busy=%b expected 0 0", VGA_we, busy);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backspace();
        test_control_codes();
        test_line_feed_wrap();
        test_clear_all();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
